// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier control stage.
package mult_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned ITER_LAST = DEF_WIDTH - 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ADD,
      SHIFT,
      HALT
   } state_e;

endpackage

// File: rtl/add_sub9.sv
// Combinational WIDTH+1-bit sign-extending adder/subtractor: sum9 = a +/- b.
module add_sub9
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH:0]   sum9
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;

   // Subtraction is invert-and-carry-in; any carry out of the top bit is dropped.
   always_comb begin
      a_ext = {a[WIDTH-1], a};
      b_ext = {b[WIDTH-1], b} ^ {(WIDTH + 1){sub}};
      sum9  = a_ext + b_ext + {{WIDTH{1'b0}}, sub};
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer, add/sub unit and X sign flop for the signed shift-add multiplier.
// Define MULT_CHAIN_EN to keep A:X across Run presses for chained multiplies.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic             Mbit,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] S_in,
   output logic             ClearXA,
   output logic             LoadA,
   output logic             LoadB,
   output logic             Shift,
   output logic             X,
   output logic [WIDTH-1:0] Sum,
   output logic             Done
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] IterLast = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             x_q;
   logic             sub;
   logic [WIDTH:0]   sum9;

   // The multiplier's MSB carries negative weight, so the last partial product is subtracted.
   assign sub = (state_q == ADD) && (cnt_q == IterLast);

   add_sub9 #(
      .WIDTH (WIDTH)
   ) u_add_sub9 (
      .a    (A_in),
      .b    (S_in),
      .sub  (sub),
      .sum9 (sum9)
   );

   assign Sum = sum9[WIDTH-1:0];
   assign X   = x_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ClearA_LoadB) begin
                  x_q <= 1'b0;
               end else if (Run) begin
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
`ifndef MULT_CHAIN_EN
               x_q <= 1'b0;
`endif
               cnt_q   <= '0;
               state_q <= ADD;
            end
            ADD: begin
               if (Mbit) begin
                  x_q <= sum9[WIDTH];
               end
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (cnt_q == IterLast) begin
                  state_q <= HALT;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= ADD;
               end
            end
            HALT: begin
               if (!Run) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes are decoded from the current state; reset forces them low immediately.
   always_comb begin
      ClearXA = 1'b0;
      LoadA   = 1'b0;
      LoadB   = 1'b0;
      Shift   = 1'b0;
      Done    = 1'b0;
      if (Reset_n) begin
         unique case (state_q)
            IDLE: begin
               ClearXA = ClearA_LoadB;
               LoadB   = ClearA_LoadB;
            end
            CLEAR: begin
`ifndef MULT_CHAIN_EN
               ClearXA = 1'b1;
`endif
            end
            ADD:     LoadA = Mbit;
            SHIFT:   Shift = 1'b1;
            HALT:    Done  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with A/B shift-register models and a product-level reference.
module tb_mult_seq_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Run;
   logic       ClearA_LoadB;
   logic       Mbit;
   logic [7:0] A_in;
   logic [7:0] S_in;
   logic       ClearXA;
   logic       LoadA;
   logic       LoadB;
   logic       Shift;
   logic       X;
   logic [7:0] Sum;
   logic       Done;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] a_reg = 8'h00;
   logic [7:0] b_reg = 8'h00;

   mult_seq_ctrl #(
      .WIDTH (8)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .Mbit         (Mbit),
      .A_in         (A_in),
      .S_in         (S_in),
      .ClearXA      (ClearXA),
      .LoadA        (LoadA),
      .LoadB        (LoadB),
      .Shift        (Shift),
      .X            (X),
      .Sum          (Sum),
      .Done         (Done)
   );

   always #5 Clk = ~Clk;

   // External A and B shift registers, as they sit around the controller.
   always @(posedge Clk) begin
      if (ClearXA)    a_reg <= 8'h00;
      else if (LoadA) a_reg <= Sum;
      else if (Shift) a_reg <= {X, a_reg[7:1]};
      if (LoadB)      b_reg <= S_in;
      else if (Shift) b_reg <= {a_reg[0], b_reg[7:1]};
   end

   assign Mbit = b_reg[0];
   assign A_in = a_reg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: step -1 idle, 0 clear, odd = add of multiplier bit (step-1)/2, even = shift,
   // 17 = halted. Partial is the exact signed sum of the partial products applied so far.
   int         m_step = -1;
   logic [7:0] m_mplier = 8'h00;
   int         m_s = 0;
   int         m_partial = 0;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_step <= -1;
      end else if (m_step == -1) begin
         if (ClearA_LoadB) begin
            m_mplier <= S_in;
         end else if (Run) begin
            m_step    <= 0;
            m_s       <= $signed(S_in);
            m_partial <= 0;
         end
      end else if (m_step <= 16) begin
         if ((m_step % 2 == 1) && m_mplier[(m_step - 1) / 2]) begin
            m_partial <= m_partial
                         + ((m_step == 15) ? -m_s : m_s) * (1 << ((m_step - 1) / 2));
         end
         m_step <= m_step + 1;
      end else if (!Run) begin
         m_step <= -1;
      end
   end

   always @(negedge Clk) begin
      logic e_clr, e_la, e_lb, e_sh, e_done;
      int   i, ea, esum;
      e_clr  = 1'b0;
      e_la   = 1'b0;
      e_lb   = 1'b0;
      e_sh   = 1'b0;
      e_done = 1'b0;
      if (Reset_n) begin
         if (m_step == -1) begin
            e_clr = ClearA_LoadB;
            e_lb  = ClearA_LoadB;
         end else if (m_step == 0) begin
            e_clr = 1'b1;
         end else if (m_step <= 16) begin
            if (m_step % 2 == 1) begin
               i    = (m_step - 1) / 2;
               e_la = m_mplier[i];
               ea   = m_partial >>> i;
               esum = (i == 7) ? ea - m_s : ea + m_s;
               chk("cyc_sum", {24'd0, Sum}, {24'd0, esum[7:0]});
            end else begin
               e_sh = 1'b1;
            end
         end else begin
            e_done = 1'b1;
         end
      end
      chk("cyc_clearxa", {31'd0, ClearXA}, {31'd0, e_clr});
      chk("cyc_loada",   {31'd0, LoadA},   {31'd0, e_la});
      chk("cyc_loadb",   {31'd0, LoadB},   {31'd0, e_lb});
      chk("cyc_shift",   {31'd0, Shift},   {31'd0, e_sh});
      chk("cyc_done",    {31'd0, Done},    {31'd0, e_done});
   end

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic load_b(input logic [7:0] v);
      S_in         = v;
      ClearA_LoadB = 1'b1;
      tick();
      ClearA_LoadB = 1'b0;
      chk("load_b_x", {31'd0, X}, 32'd0);
   endtask

   task automatic wait_done(input int exp_cyc);
      int  cyc;
      bit  seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge Clk);
         cyc++;
         if (Done) seen = 1'b1;
      end
      chk("done_latency", cyc, exp_cyc);
   endtask

   task automatic finish_check(input string name, input logic [7:0] bv, input logic [7:0] sv,
                               input logic [7:0] ea, input logic [7:0] eb, input logic ex,
                               input int hold);
      int          prod;
      logic [15:0] p16;
      prod = $signed(bv) * $signed(sv);
      p16  = prod[15:0];
      chk({name, "_a"}, {24'd0, a_reg}, {24'd0, ea});
      chk({name, "_b"}, {24'd0, b_reg}, {24'd0, eb});
      chk({name, "_x"}, {31'd0, X}, {31'd0, ex});
      chk({name, "_prod"}, {16'd0, a_reg, b_reg}, {16'd0, p16});
      chk({name, "_xsign"}, {31'd0, X}, {31'd0, p16[15]});
      repeat (hold) tick();
      if (hold > 0) chk({name, "_held_done"}, {31'd0, Done}, 32'd1);
      Run = 1'b0;
      tick();
      tick();
      chk({name, "_idle_done"}, {31'd0, Done}, 32'd0);
   endtask

   task automatic multiply(input string name, input logic [7:0] bv, input logic [7:0] sv,
                           input logic [7:0] ea, input logic [7:0] eb, input logic ex,
                           input int hold);
      load_b(bv);
      S_in = sv;
      Run  = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      chk({name, "_clear"}, {31'd0, ClearXA}, 32'd1);
      wait_done(17);
      finish_check(name, bv, sv, ea, eb, ex, hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      Reset_n      = 1'b0;
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      S_in         = 8'h00;
      #3;
      chk("rst_strobes", {27'd0, ClearXA, LoadA, LoadB, Shift, Done}, 32'd0);
      chk("rst_x", {31'd0, X}, 32'd0);
      #9;
      Reset_n = 1'b1;
      tick();

      multiply("m_3b_07", 8'h3B, 8'h07, 8'h01, 8'h9D, 1'b0, 0);
      multiply("m_3b_f9", 8'h3B, 8'hF9, 8'hFE, 8'h63, 1'b1, 0);
      multiply("m_c5_07", 8'hC5, 8'h07, 8'hFE, 8'h63, 1'b1, 0);
      multiply("m_c5_f9", 8'hC5, 8'hF9, 8'h01, 8'h9D, 1'b0, 5);

      // Both controls at once: the load wins, Run is taken one cycle later.
      S_in         = 8'h80;
      ClearA_LoadB = 1'b1;
      Run          = 1'b1;
      @(negedge Clk);
      chk("both_c1_clearxa", {31'd0, ClearXA}, 32'd1);
      chk("both_c1_loadb", {31'd0, LoadB}, 32'd1);
      tick();
      ClearA_LoadB = 1'b0;
      @(negedge Clk);
      chk("both_c2_clearxa", {31'd0, ClearXA}, 32'd0);
      @(negedge Clk);
      chk("both_c3_clearxa", {31'd0, ClearXA}, 32'd1);
      chk("both_c3_loadb", {31'd0, LoadB}, 32'd0);
      wait_done(17);
      finish_check("m_80_80", 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 0);

      // Abort mid-SHIFT while X is set by the first negative partial product.
      load_b(8'h3B);
      S_in  = 8'hF9;
      Run   = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge Clk);
         if (Shift) found = 1'b1;
      end
      chk("abort_reached_shift", {31'd0, found}, 32'd1);
      chk("abort_pre_x", {31'd0, X}, 32'd1);
      #1;
      Reset_n = 1'b0;
      Run     = 1'b0;
      #1;
      chk("abort_strobes", {27'd0, ClearXA, LoadA, LoadB, Shift, Done}, 32'd0);
      chk("abort_x", {31'd0, X}, 32'd0);
      @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      tick();
      chk("abort_after_x", {31'd0, X}, 32'd0);
      chk("abort_after_done", {31'd0, Done}, 32'd0);

      multiply("m_post_rst", 8'hC5, 8'hF9, 8'h01, 8'h9D, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
